// File: rtl/mau_pkg.sv
// Shared types and widths for the matrix accumulate sequencer and its term counter.
package mau_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} mau_seq_state_t;

  localparam int MAU_DATA_WIDTH = 64;
  localparam int MAU_LEN_WIDTH  = 8;

endpackage

// File: rtl/mau_term_counter.sv
// Tracks the terms still owed to the current job and the terms already summed.
module mau_term_counter
  import mau_pkg::*;
#(
  parameter int LEN_WIDTH = MAU_LEN_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 beat_i,
  output logic                 last_o,
  output logic [LEN_WIDTH-1:0] count_o
);

  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;

  // A load always restarts the summed count, even for an empty job.
  always_comb begin
    remaining_d = remaining_q;
    count_d     = count_q;
    if (load_i) begin
      remaining_d = len_i;
      count_d     = '0;
    end else if (beat_i) begin
      remaining_d = remaining_q - LEN_WIDTH'(1);
      count_d     = count_q + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      remaining_q <= '0;
      count_q     <= '0;
    end else begin
      remaining_q <= remaining_d;
      count_q     <= count_d;
    end
  end

  assign last_o  = (remaining_q == LEN_WIDTH'(1));
  assign count_o = count_q;

endmodule

// File: rtl/matrix_accumulate_sequencer.sv
// Sequences one dot-product job: start with a term count, sum that many partial
// products from the input stream, then hold the result until the consumer takes it.
module matrix_accumulate_sequencer
  import mau_pkg::*;
#(
  parameter int DATA_WIDTH = MAU_DATA_WIDTH,
  parameter int LEN_WIDTH  = MAU_LEN_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  abort,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [LEN_WIDTH-1:0]  out_count
);

  mau_seq_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  load;
  logic                  beat;
  logic                  last;

  assign load = (state_q == IDLE) && start;
  // An abort in the same cycle as a beat wins, so that beat is neither summed nor counted.
  assign beat = (state_q == ACCUM) && in_valid && !abort;

  mau_term_counter #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_term_counter (
    .clock  (clock),
    .reset  (reset),
    .load_i (load),
    .len_i  (len),
    .beat_i (beat),
    .last_o (last),
    .count_o(out_count)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sum_d   = '0;
          state_d = (len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (abort) begin
          state_d = DONE;
        end else if (in_valid) begin
          sum_d = sum_q + in_data;
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
    end
  end

  // All handshake outputs decode registered state only.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM) || (state_q == DONE);
  assign out_data  = sum_q;

endmodule

// File: tb/tb_matrix_accumulate_sequencer.sv
// Directed bench for matrix_accumulate_sequencer; results are checked by a
// scoreboard monitor that pops expected sums whenever a result is handed over.
module tb_matrix_accumulate_sequencer;

  localparam int DW = 64;
  localparam int LW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [LW-1:0] count;
  } expResult_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          abort;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [LW-1:0] out_count;

  expResult_t expQueue[$];
  int checkCount = 0;
  int failCount  = 0;

  matrix_accumulate_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .abort    (abort),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .out_count(out_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one cycle; inputs change just after the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] data);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic startJob(input logic [LW-1:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard monitor: a handshake sampled here completes on the next rising edge.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (expQueue.size() == 0) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL unexpected_result: got data 0x%0h count %0d, expected none",
                 out_data, out_count);
      end else begin
        expResult_t e;
        e = expQueue.pop_front();
        checkOutput("result_data", out_data, e.data);
        checkOutput("result_count", DW'(out_count), DW'(e.count));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    abort     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset_busy", DW'(busy), 0);
    checkOutput("reset_in_ready", DW'(in_ready), 0);
    checkOutput("reset_out_valid", DW'(out_valid), 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_count", DW'(out_count), 0);

    // Four back-to-back beats, result one cycle after the last.
    expQueue.push_back('{data: 64'd10, count: 8'd4});
    startJob(8'd4);
    checkOutput("t1_in_ready", DW'(in_ready), 1);
    checkOutput("t1_busy", DW'(busy), 1);
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      tick();
    end
    in_valid = 1'b0;
    checkOutput("t1_out_valid_latency", DW'(out_valid), 1);
    checkOutput("t1_out_data", out_data, 64'd10);
    tick();
    checkOutput("t1_idle_out_valid", DW'(out_valid), 0);
    checkOutput("t1_idle_busy", DW'(busy), 0);

    // Bubbles carry junk data that must not be summed.
    expQueue.push_back('{data: 64'd21, count: 8'd3});
    startJob(8'd3);
    checkOutput("t2_in_ready_0", DW'(in_ready), 1);
    applyStimulus(64'd5);
    checkOutput("t2_in_ready_1", DW'(in_ready), 1);
    in_data = 64'd100;
    tick();
    checkOutput("t2_in_ready_2", DW'(in_ready), 1);
    checkOutput("t2_count_held", DW'(out_count), 1);
    applyStimulus(64'd7);
    checkOutput("t2_in_ready_3", DW'(in_ready), 1);
    in_data = 64'd100;
    tick();
    checkOutput("t2_in_ready_4", DW'(in_ready), 1);
    applyStimulus(64'd9);
    checkOutput("t2_out_valid", DW'(out_valid), 1);
    tick();

    // Sum wraps modulo 2**64.
    expQueue.push_back('{data: 64'd1, count: 8'd2});
    startJob(8'd2);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(64'd2);
    checkOutput("t3_out_valid", DW'(out_valid), 1);
    tick();

    // Empty job, result held under backpressure while start pulses are ignored.
    out_ready = 1'b0;
    expQueue.push_back('{data: 64'd0, count: 8'd0});
    startJob(8'd0);
    checkOutput("t4_out_valid", DW'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      len   = 8'd7;
      tick();
      checkOutput("t4_hold_out_valid", DW'(out_valid), 1);
      checkOutput("t4_hold_out_data", out_data, 0);
      checkOutput("t4_hold_out_count", DW'(out_count), 0);
      checkOutput("t4_hold_in_ready", DW'(in_ready), 0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("t4_released", DW'(out_valid), 0);

    // Abort beats a same-cycle beat.
    expQueue.push_back('{data: 64'd30, count: 8'd2});
    startJob(8'd5);
    applyStimulus(64'd10);
    applyStimulus(64'd20);
    abort = 1'b1;
    applyStimulus(64'd99);
    abort = 1'b0;
    checkOutput("t5_out_valid", DW'(out_valid), 1);
    checkOutput("t5_out_data", out_data, 64'd30);
    tick();

    // Reset mid-job discards everything, then a fresh job runs normally.
    startJob(8'd5);
    applyStimulus(64'd1);
    applyStimulus(64'd2);
    applyStimulus(64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_busy", DW'(busy), 0);
    checkOutput("t6_in_ready", DW'(in_ready), 0);
    checkOutput("t6_out_valid", DW'(out_valid), 0);
    checkOutput("t6_out_data", out_data, 0);
    checkOutput("t6_out_count", DW'(out_count), 0);
    expQueue.push_back('{data: 64'd8, count: 8'd1});
    startJob(8'd1);
    applyStimulus(64'd8);
    checkOutput("t6_out_valid_new", DW'(out_valid), 1);
    tick();
    tick();

    checkOutput("scoreboard_drained", DW'(expQueue.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
